// File: rtl/core_wb_stage.sv
// rtl/core_wb_stage.sv - writeback stage: MEM->WB register, load wait, result select
//
// Purpose:
//   Registers the instruction leaving MEM and produces the register-file write
//   (also used by the EX forwarding path). If the registered instruction is a
//   load, the stage stalls upstream until data memory returns the word. It then
//   extracts the byte, half or word and writes it, or drops a misaligned load.
//   The stage also counts retired instructions.
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   valid_i / ready_o             MEM->WB handshake; capture on valid_i && ready_o
//   pc_i, opcode_i, funct3_i,     instruction fields from MEM
//   rd_i, is_muldiv_i
//   alu_result_i, mul_result_i    candidate results (alu_result_i is the load address)
//   dmem_rvalid_i, dmem_rdata_i   load response (aligned 32-bit word)
//   wb_rd_o, wb_reg_write_o,      register-file / forwarding write port
//   rd_din_o
//   misalign_o                    pulses when a misaligned load retires without writing
//   instret_o                     64-bit retired-instruction counter

module core_wb_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic [6:0]      opcode_i,
  input  logic [2:0]      funct3_i,
  input  logic [4:0]      rd_i,
  input  logic            is_muldiv_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [XLEN-1:0] mul_result_i,
  input  logic            dmem_rvalid_i,
  input  logic [31:0]     dmem_rdata_i,
  output logic [4:0]      wb_rd_o,
  output logic            wb_reg_write_o,
  output logic [XLEN-1:0] rd_din_o,
  output logic            misalign_o,
  output logic [63:0]     instret_o
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [6:0]      opcode_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic            is_muldiv_q;
  logic [XLEN-1:0] alu_result_q;
  logic [XLEN-1:0] mul_result_q;

  logic        is_load;
  logic        wait_ld;
  logic        retire;
  logic        writes_rd;
  logic        misalign;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;

  assign is_load = (opcode_q == OPC_LOAD);
  // A registered load holds the stage until its data arrives; a response
  // with no load waiting simply has no effect.
  assign wait_ld = valid_q && is_load && !dmem_rvalid_i;
  assign ready_o = !wait_ld;
  assign retire  = valid_q && !wait_ld;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      opcode_q     <= '0;
      funct3_q     <= '0;
      rd_q         <= '0;
      is_muldiv_q  <= 1'b0;
      alu_result_q <= '0;
      mul_result_q <= '0;
      instret_o    <= '0;
    end else begin
      // While waiting the entry is frozen; otherwise it is consumed and
      // replaced by whatever MEM presents (possibly nothing).
      if (ready_o) begin
        valid_q <= valid_i;
        if (valid_i) begin
          pc_q         <= pc_i;
          opcode_q     <= opcode_i;
          funct3_q     <= funct3_i;
          rd_q         <= rd_i;
          is_muldiv_q  <= is_muldiv_i;
          alu_result_q <= alu_result_i;
          mul_result_q <= mul_result_i;
        end
      end
      if (retire) begin
        instret_o <= instret_o + 64'd1;
      end
    end
  end

  always_comb begin
    writes_rd = 1'b0;
    case (opcode_q)
      OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP_IMM, OPC_JAL, OPC_JALR: writes_rd = 1'b1;
      OPC_LOAD: writes_rd = (funct3_q inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
      default:  writes_rd = 1'b0;
    endcase
  end

  assign misalign = is_load &&
                    ((((funct3_q == F3_LH) || (funct3_q == F3_LHU)) && alu_result_q[0]) ||
                     ((funct3_q == F3_LW) && (alu_result_q[1:0] != 2'b00)));

  // A misaligned load still retires, so the pulse lines up with its retire cycle.
  assign misalign_o     = retire && misalign;
  assign wb_reg_write_o = valid_q && writes_rd && (rd_q != 5'd0) && !wait_ld && !misalign;
  assign wb_rd_o        = rd_q;

  always_comb begin
    ld_byte = dmem_rdata_i[7:0];
    case (alu_result_q[1:0])
      2'd0: ld_byte = dmem_rdata_i[7:0];
      2'd1: ld_byte = dmem_rdata_i[15:8];
      2'd2: ld_byte = dmem_rdata_i[23:16];
      2'd3: ld_byte = dmem_rdata_i[31:24];
      default: ld_byte = dmem_rdata_i[7:0];
    endcase
  end

  assign ld_half = alu_result_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

  always_comb begin
    load_data = dmem_rdata_i;
    case (funct3_q)
      F3_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
      F3_LBU:  load_data = {24'd0, ld_byte};
      F3_LH:   load_data = {{16{ld_half[15]}}, ld_half};
      F3_LHU:  load_data = {16'd0, ld_half};
      default: load_data = dmem_rdata_i;
    endcase
  end

  always_comb begin
    rd_din_o = alu_result_q;
    if ((opcode_q == OPC_JAL) || (opcode_q == OPC_JALR)) begin
      rd_din_o = pc_q + XLEN'(4);
    end else if ((opcode_q == OPC_OP) && is_muldiv_q) begin
      rd_din_o = mul_result_q;
    end else if (is_load) begin
      rd_din_o = XLEN'(load_data);
    end
  end

endmodule

// File: tb/tb_core_wb_stage.sv
// tb/tb_core_wb_stage.sv - directed table-driven bench for core_wb_stage

module tb_core_wb_stage;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] OPIMM  = 7'b0010011;
  localparam logic [6:0] AUIPC  = 7'b0010111;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] LUI    = 7'b0110111;
  localparam logic [6:0] JALR   = 7'b1100111;
  localparam logic [6:0] JAL    = 7'b1101111;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011;
  localparam logic [6:0] SYSTEM = 7'b1110011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [31:0] pc_i = '0;
  logic [6:0]  opcode_i = '0;
  logic [2:0]  funct3_i = '0;
  logic [4:0]  rd_i = '0;
  logic        is_muldiv_i = 1'b0;
  logic [31:0] alu_result_i = '0;
  logic [31:0] mul_result_i = '0;
  logic        dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_rdata_i = '0;
  logic [4:0]  wb_rd_o;
  logic        wb_reg_write_o;
  logic [31:0] rd_din_o;
  logic        misalign_o;
  logic [63:0] instret_o;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_instret = '0;

  core_wb_stage #(.XLEN(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_i), .ready_o(ready_o),
    .pc_i(pc_i), .opcode_i(opcode_i), .funct3_i(funct3_i), .rd_i(rd_i),
    .is_muldiv_i(is_muldiv_i), .alu_result_i(alu_result_i), .mul_result_i(mul_result_i),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .wb_rd_o(wb_rd_o), .wb_reg_write_o(wb_reg_write_o), .rd_din_o(rd_din_o),
    .misalign_o(misalign_o), .instret_o(instret_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        muldiv;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] mul;
    logic        rvalid;
    logic [31:0] rdata;
    logic        exp_we;
    logic [31:0] exp_din;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd,
                       input logic md, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] mul);
    valid_i = 1'b1; opcode_i = opc; funct3_i = f3; rd_i = rd;
    is_muldiv_i = md; pc_i = pc; alu_result_i = alu; mul_result_i = mul;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    vecs.push_back('{"addi",     OPIMM,  3'd0, 5'd5,  1'b0, 32'h0,        32'h1234,     32'h0,        1'b0, 32'h0, 1'b1, 32'h1234,     1'b0});
    vecs.push_back('{"op_rd0",   OP,     3'd0, 5'd0,  1'b0, 32'h0,        32'h55,       32'h0,        1'b0, 32'h0, 1'b0, 32'h55,       1'b0});
    vecs.push_back('{"mul",      OP,     3'd0, 5'd7,  1'b1, 32'h0,        32'h1,        32'hDEAD0000, 1'b0, 32'h0, 1'b1, 32'hDEAD0000, 1'b0});
    vecs.push_back('{"jal_wrap", JAL,    3'd0, 5'd1,  1'b0, 32'hFFFFFFFC, 32'h20,       32'h0,        1'b0, 32'h0, 1'b1, 32'h0,        1'b0});
    vecs.push_back('{"jalr",     JALR,   3'd0, 5'd2,  1'b0, 32'h100,      32'h999,      32'h0,        1'b0, 32'h0, 1'b1, 32'h104,      1'b0});
    vecs.push_back('{"lui",      LUI,    3'd0, 5'd3,  1'b0, 32'h0,        32'hABCDE000, 32'h0,        1'b0, 32'h0, 1'b1, 32'hABCDE000, 1'b0});
    vecs.push_back('{"auipc",    AUIPC,  3'd0, 5'd4,  1'b0, 32'h0,        32'h1000,     32'h0,        1'b0, 32'h0, 1'b1, 32'h1000,     1'b0});
    vecs.push_back('{"store",    STORE,  3'd2, 5'd9,  1'b0, 32'h0,        32'h40,       32'h0,        1'b0, 32'h0, 1'b0, 32'h40,       1'b0});
    vecs.push_back('{"branch",   BRANCH, 3'd0, 5'd10, 1'b0, 32'h0,        32'h8,        32'h0,        1'b0, 32'h0, 1'b0, 32'h8,        1'b0});
    vecs.push_back('{"opimm_md", OPIMM,  3'd0, 5'd11, 1'b1, 32'h0,        32'h77,       32'h88,       1'b0, 32'h0, 1'b1, 32'h77,       1'b0});
    vecs.push_back('{"system",   SYSTEM, 3'd0, 5'd12, 1'b0, 32'h0,        32'h3,        32'h0,        1'b0, 32'h0, 1'b0, 32'h3,        1'b0});
    vecs.push_back('{"lb_off3",  LOAD,   3'd0, 5'd13, 1'b0, 32'h0, 32'h103, 32'h0, 1'b1, 32'h80112233, 1'b1, 32'hFFFFFF80, 1'b0});
    vecs.push_back('{"lbu_off3", LOAD,   3'd4, 5'd14, 1'b0, 32'h0, 32'h103, 32'h0, 1'b1, 32'h80112233, 1'b1, 32'h00000080, 1'b0});
    vecs.push_back('{"lb_off0",  LOAD,   3'd0, 5'd15, 1'b0, 32'h0, 32'h100, 32'h0, 1'b1, 32'h80112233, 1'b1, 32'h00000033, 1'b0});
    vecs.push_back('{"lh_off2",  LOAD,   3'd1, 5'd16, 1'b0, 32'h0, 32'h102, 32'h0, 1'b1, 32'h80112233, 1'b1, 32'hFFFF8011, 1'b0});
    vecs.push_back('{"lhu_off0", LOAD,   3'd5, 5'd17, 1'b0, 32'h0, 32'h100, 32'h0, 1'b1, 32'h80112233, 1'b1, 32'h00002233, 1'b0});
    vecs.push_back('{"lw_off0",  LOAD,   3'd2, 5'd18, 1'b0, 32'h0, 32'h200, 32'h0, 1'b1, 32'h80112233, 1'b1, 32'h80112233, 1'b0});
    vecs.push_back('{"lh_mis",   LOAD,   3'd1, 5'd19, 1'b0, 32'h0, 32'h101, 32'h0, 1'b1, 32'h80112233, 1'b0, 32'h00002233, 1'b1});
    vecs.push_back('{"lw_mis",   LOAD,   3'd2, 5'd20, 1'b0, 32'h0, 32'h202, 32'h0, 1'b1, 32'h80112233, 1'b0, 32'h80112233, 1'b1});
    vecs.push_back('{"lw_rd0",   LOAD,   3'd2, 5'd0,  1'b0, 32'h0, 32'h0,   32'h0, 1'b1, 32'h80112233, 1'b0, 32'h80112233, 1'b0});

    // Reset state
    #1;
    chk("rst_ready", ready_o, 1'b1);
    chk("rst_we", wb_reg_write_o, 1'b0);
    chk("rst_rd", wb_rd_o, 5'd0);
    chk("rst_din", rd_din_o, 32'h0);
    chk("rst_mis", misalign_o, 1'b0);
    chk("rst_instret", instret_o, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table: one instruction per two cycles, load data returned immediately
    foreach (vecs[i]) begin
      @(negedge clk);
      dmem_rvalid_i = 1'b0;
      drive(vecs[i].opcode, vecs[i].funct3, vecs[i].rd, vecs[i].muldiv,
            vecs[i].pc, vecs[i].alu, vecs[i].mul);
      @(posedge clk);
      @(negedge clk);
      valid_i = 1'b0;
      dmem_rvalid_i = vecs[i].rvalid;
      dmem_rdata_i = vecs[i].rdata;
      #1;
      chk({vecs[i].name, "_we"}, wb_reg_write_o, vecs[i].exp_we);
      chk({vecs[i].name, "_rd"}, wb_rd_o, vecs[i].rd);
      chk({vecs[i].name, "_din"}, rd_din_o, vecs[i].exp_din);
      chk({vecs[i].name, "_mis"}, misalign_o, vecs[i].exp_mis);
      chk({vecs[i].name, "_ready"}, ready_o, 1'b1);
      chk({vecs[i].name, "_instret"}, instret_o, exp_instret);
      exp_instret++;
      @(posedge clk);
    end
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    #1;
    chk("table_instret_final", instret_o, exp_instret);

    // LB with data three cycles late; next instruction waits and is taken on the rvalid cycle
    @(negedge clk);
    drive(LOAD, 3'd0, 5'd21, 1'b0, 32'h0, 32'h103, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive(OPIMM, 3'd0, 5'd22, 1'b0, 32'h0, 32'h42, 32'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("lbwait_ready", ready_o, 1'b0);
      chk("lbwait_we", wb_reg_write_o, 1'b0);
      chk("lbwait_instret", instret_o, exp_instret);
      @(posedge clk);
      @(negedge clk);
    end
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'h80112233;
    #1;
    chk("lbdone_ready", ready_o, 1'b1);
    chk("lbdone_we", wb_reg_write_o, 1'b1);
    chk("lbdone_rd", wb_rd_o, 5'd21);
    chk("lbdone_din", rd_din_o, 32'hFFFFFF80);
    @(posedge clk);
    exp_instret++;
    @(negedge clk);
    valid_i = 1'b0;
    dmem_rvalid_i = 1'b0;
    #1;
    chk("after_lb_we", wb_reg_write_o, 1'b1);
    chk("after_lb_rd", wb_rd_o, 5'd22);
    chk("after_lb_din", rd_din_o, 32'h42);
    chk("after_lb_instret", instret_o, exp_instret);
    @(posedge clk);
    exp_instret++;

    // LW back-to-back with ADD
    @(negedge clk);
    drive(LOAD, 3'd2, 5'd23, 1'b0, 32'h0, 32'h300, 32'h0);
    @(posedge clk);
    @(negedge clk);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'hCAFEF00D;
    drive(OP, 3'd0, 5'd24, 1'b0, 32'h0, 32'h11, 32'h0);
    #1;
    chk("b2b_lw_we", wb_reg_write_o, 1'b1);
    chk("b2b_lw_rd", wb_rd_o, 5'd23);
    chk("b2b_lw_din", rd_din_o, 32'hCAFEF00D);
    @(posedge clk);
    exp_instret++;
    @(negedge clk);
    valid_i = 1'b0;
    dmem_rvalid_i = 1'b0;
    #1;
    chk("b2b_add_we", wb_reg_write_o, 1'b1);
    chk("b2b_add_rd", wb_rd_o, 5'd24);
    chk("b2b_add_din", rd_din_o, 32'h11);
    @(posedge clk);
    exp_instret++;
    @(negedge clk);
    #1;
    chk("b2b_instret", instret_o, exp_instret);

    // Reset during a load wait, then a stray response
    @(negedge clk);
    drive(LOAD, 3'd2, 5'd25, 1'b0, 32'h0, 32'h400, 32'h0);
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    chk("rstwait_ready_pre", ready_o, 1'b0);
    rst_n = 1'b0;
    #1;
    exp_instret = '0;
    chk("rstwait_ready", ready_o, 1'b1);
    chk("rstwait_we", wb_reg_write_o, 1'b0);
    chk("rstwait_rd", wb_rd_o, 5'd0);
    chk("rstwait_din", rd_din_o, 32'h0);
    chk("rstwait_instret", instret_o, exp_instret);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 32'h12345678;
    #1;
    chk("stray_rvalid_we", wb_reg_write_o, 1'b0);
    chk("stray_rvalid_mis", misalign_o, 1'b0);
    @(posedge clk);
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    #1;
    chk("stray_rvalid_instret", instret_o, exp_instret);

    // Counter wrap
    @(negedge clk);
    force dut.instret_o = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_o;
    #1;
    exp_instret = 64'hFFFF_FFFF_FFFF_FFFF;
    chk("wrap_preset", instret_o, exp_instret);
    @(negedge clk);
    drive(OPIMM, 3'd0, 5'd26, 1'b0, 32'h0, 32'h5, 32'h0);
    @(posedge clk);
    @(negedge clk);
    valid_i = 1'b0;
    #1;
    chk("wrap_we", wb_reg_write_o, 1'b1);
    @(posedge clk);
    exp_instret = exp_instret + 64'd1;
    @(negedge clk);
    #1;
    chk("wrap_instret", instret_o, exp_instret);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
